// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: per-unit result push ports plus the registered CDB broadcast.
interface cdb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 6
);
   logic              int_valid, mem_valid, mult_valid, div_valid;
   logic              int_ready, mem_ready, mult_ready, div_ready;
   logic [TAG_W-1:0]  int_tag, mem_tag, mult_tag, div_tag;
   logic [DATA_W-1:0] int_data, mem_data, mult_data, div_data;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic [1:0]        cdb_src;

   modport master (
      output int_valid, mem_valid, mult_valid, div_valid,
      output int_tag, mem_tag, mult_tag, div_tag,
      output int_data, mem_data, mult_data, div_data,
      input  int_ready, mem_ready, mult_ready, div_ready,
      input  cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport slave (
      input  int_valid, mem_valid, mult_valid, div_valid,
      input  int_tag, mem_tag, mult_tag, div_tag,
      input  int_data, mem_data, mult_data, div_data,
      output int_ready, mem_ready, mult_ready, div_ready,
      output cdb_valid, cdb_tag, cdb_data, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: four result FIFOs (int, mem, mult, div) arbitrated onto one registered CDB
// with div > mult > LRU(int, mem) priority and a per-source starvation guard.
module cdb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int TAG_W        = 6,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input logic         clk,
   input logic         rst_n,
   input logic         flush,
   cdb_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = TAG_W + DATA_W;
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);

   logic [3:0]    in_valid, ready, push, pop, ne, starved;
   logic [EW-1:0] in_word [4];
   logic [EW-1:0] fifo [4][DEPTH];
   logic [AW-1:0] rd [4];
   logic [AW-1:0] wr [4];
   logic [AW:0]   cnt [4];
   logic [SW-1:0] starve [4];
   logic [EW-1:0] head;
   logic [1:0]    sel;
   logic          any, lru;

   assign in_valid   = {bus.div_valid, bus.mult_valid, bus.mem_valid, bus.int_valid};
   assign in_word[0] = {bus.int_tag, bus.int_data};
   assign in_word[1] = {bus.mem_tag, bus.mem_data};
   assign in_word[2] = {bus.mult_tag, bus.mult_data};
   assign in_word[3] = {bus.div_tag, bus.div_data};
   assign {bus.div_ready, bus.mult_ready, bus.mem_ready, bus.int_ready} = ready;
   assign push = in_valid & ready;
   assign head = fifo[sel][rd[sel]];

   // Starved sources outrank everything; the order among them is fixed int..div.
   always_comb begin
      ne      = '0;
      ready   = '0;
      starved = '0;
      for (int i = 0; i < 4; i++) begin
         ne[i]      = cnt[i] != '0;
         ready[i]   = (cnt[i] < FULL) && !flush;
         starved[i] = ne[i] && (starve[i] == LIM);
      end
      any = (|ne) && !flush;
      sel = starved[0] ? 2'd0 : starved[1] ? 2'd1 : starved[2] ? 2'd2 : starved[3] ? 2'd3 :
            ne[3] ? 2'd3 : ne[2] ? 2'd2 :
            (ne[0] && ne[1]) ? (lru ? 2'd0 : 2'd1) : ne[0] ? 2'd0 : 2'd1;
      pop = any ? (4'b0001 << sel) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (push[i]) fifo[i][wr[i]] <= in_word[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            rd[i]     <= '0;
            wr[i]     <= '0;
            cnt[i]    <= '0;
            starve[i] <= '0;
         end
         lru           <= 1'b1;
         bus.cdb_valid <= 1'b0;
         bus.cdb_tag   <= '0;
         bus.cdb_data  <= '0;
         bus.cdb_src   <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            rd[i]     <= flush ? '0 : rd[i] + AW'(pop[i]);
            wr[i]     <= flush ? '0 : wr[i] + AW'(push[i]);
            cnt[i]    <= flush ? '0 : cnt[i] + (AW + 1)'(push[i]) - (AW + 1)'(pop[i]);
            starve[i] <= (flush || pop[i] || !ne[i]) ? '0 :
                         (starve[i] == LIM) ? LIM : starve[i] + SW'(1);
         end
         bus.cdb_valid <= any;
         if (any) begin
            {bus.cdb_tag, bus.cdb_data} <= head;
            bus.cdb_src                 <= sel;
            lru                         <= (sel == 2'd0) ? 1'b0 : (sel == 2'd1) ? 1'b1 : lru;
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios checked every cycle against a queue-based model of the arbiter,
// plus literal expectations for the headline cases.
module tb_cdb_arbiter;
   localparam int DW = 32, TW = 6, DEPTH = 2, LIM = 4;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.DATA_W(DW), .TAG_W(TW)) bus ();
   cdb_arbiter #(.DATA_W(DW), .TAG_W(TW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
   );

   int total = 0, bad = 0;
   logic [TW+DW-1:0] q [4][$];
   int stv [4];
   bit mlru;
   logic ev;
   logic [TW-1:0] et;
   logic [DW-1:0] ed;
   logic [1:0] es;
   logic [7:0] log_q [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: per-source queues, grant chosen from the priority rules on pre-edge occupancy.
   always @(posedge clk or negedge rst_n) begin
      int g;
      int sz [4];
      logic [3:0] v;
      logic [TW+DW-1:0] w [4];
      if (!rst_n) begin
         for (int s = 0; s < 4; s++) begin q[s].delete(); stv[s] = 0; end
         mlru = 1'b1; ev = 1'b0; et = '0; ed = '0; es = '0;
      end else if (flush) begin
         for (int s = 0; s < 4; s++) begin q[s].delete(); stv[s] = 0; end
         ev = 1'b0;
      end else begin
         v = {bus.div_valid, bus.mult_valid, bus.mem_valid, bus.int_valid};
         w[0] = {bus.int_tag, bus.int_data};
         w[1] = {bus.mem_tag, bus.mem_data};
         w[2] = {bus.mult_tag, bus.mult_data};
         w[3] = {bus.div_tag, bus.div_data};
         for (int s = 0; s < 4; s++) sz[s] = q[s].size();
         g = -1;
         for (int s = 0; s < 4; s++) if (g < 0 && sz[s] > 0 && stv[s] >= LIM) g = s;
         if (g < 0)
            g = sz[3] > 0 ? 3 : sz[2] > 0 ? 2 : (sz[0] > 0 && sz[1] > 0) ? (mlru ? 0 : 1) :
                sz[0] > 0 ? 0 : sz[1] > 0 ? 1 : -1;
         for (int s = 0; s < 4; s++)
            stv[s] = (s == g || sz[s] == 0) ? 0 : (stv[s] + 1 > LIM ? LIM : stv[s] + 1);
         if (g >= 0) begin
            {et, ed} = q[g].pop_front();
            es = 2'(g);
            ev = 1'b1;
            if (g == 0) mlru = 1'b0;
            if (g == 1) mlru = 1'b1;
         end else ev = 1'b0;
         for (int s = 0; s < 4; s++) if (v[s] && sz[s] < DEPTH) q[s].push_back(w[s]);
      end
   end

   always @(negedge clk) begin
      logic [3:0] rdy;
      if (rst_n) begin
         rdy = {bus.div_ready, bus.mult_ready, bus.mem_ready, bus.int_ready};
         chk("cdb_valid", 64'(bus.cdb_valid), 64'(ev));
         chk("cdb_tag", 64'(bus.cdb_tag), 64'(et));
         chk("cdb_data", 64'(bus.cdb_data), 64'(ed));
         chk("cdb_src", 64'(bus.cdb_src), 64'(es));
         for (int s = 0; s < 4; s++)
            chk($sformatf("ready%0d", s), 64'(rdy[s]), 64'(q[s].size() < DEPTH && !flush));
         if (bus.cdb_valid) log_q.push_back({bus.cdb_src, bus.cdb_tag});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.int_valid = 0; bus.mem_valid = 0; bus.mult_valid = 0; bus.div_valid = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #4;
      rst_n = 1'b1;
   endtask

   task automatic chk_log(input string nm, input int idx, input int src, input int tag);
      logic [7:0] a;
      a = (idx < log_q.size()) ? log_q[idx] : 8'hff;
      chk(nm, 64'(a), 64'({src[1:0], tag[5:0]}));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] memlog [$];
      int n, ni, mi;
      idle();
      bus.int_tag = 0; bus.mem_tag = 0; bus.mult_tag = 0; bus.div_tag = 0;
      bus.int_data = 0; bus.mem_data = 0; bus.mult_data = 0; bus.div_data = 0;
      #11;
      chk("rst_valid", 64'(bus.cdb_valid), 0);
      chk("rst_tag", 64'(bus.cdb_tag), 0);
      chk("rst_data", 64'(bus.cdb_data), 0);
      chk("rst_src", 64'(bus.cdb_src), 0);
      #1 rst_n = 1'b1;
      #1 chk("rst_ready", 64'({bus.div_ready, bus.mult_ready, bus.mem_ready, bus.int_ready}), 64'hf);
      tick();

      // single push: visible two edges after acceptance, for one cycle only
      bus.int_valid = 1; bus.int_tag = 5; bus.int_data = 32'h1234;
      tick();
      idle();
      chk("single_lat_valid", 64'(bus.cdb_valid), 0);
      chk("single_ready", 64'(bus.int_ready), 1);
      tick();
      chk("single_valid", 64'(bus.cdb_valid), 1);
      chk("single_tag", 64'(bus.cdb_tag), 5);
      chk("single_data", 64'(bus.cdb_data), 32'h1234);
      chk("single_src", 64'(bus.cdb_src), 0);
      tick();
      chk("single_done", 64'(bus.cdb_valid), 0);

      // fixed priority div > mult > int
      bus.div_valid = 1; bus.div_tag = 1; bus.div_data = 32'hd1;
      bus.mult_valid = 1; bus.mult_tag = 2; bus.mult_data = 32'hc2;
      bus.int_valid = 1; bus.int_tag = 3; bus.int_data = 32'ha3;
      tick();
      idle();
      tick();
      chk("prio0", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_tag}), 64'({1'b1, 2'd3, 6'd1}));
      tick();
      chk("prio1", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_tag}), 64'({1'b1, 2'd2, 6'd2}));
      tick();
      chk("prio2", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_tag}), 64'({1'b1, 2'd0, 6'd3}));
      tick();

      // LRU alternation between int and mem
      do_reset();
      log_q.delete();
      ni = 10; mi = 20;
      for (int i = 0; i < 8; i++) begin
         bus.int_valid = bus.int_ready; bus.int_tag = 6'(ni); bus.int_data = 32'(ni * 3);
         bus.mem_valid = bus.mem_ready; bus.mem_tag = 6'(mi); bus.mem_data = 32'(mi * 5);
         tick();
         if (bus.int_valid) ni++;
         if (bus.mem_valid) mi++;
      end
      idle();
      repeat (4) tick();
      chk_log("lru0", 0, 0, 10);
      chk_log("lru1", 1, 1, 20);
      chk_log("lru2", 2, 0, 11);
      chk_log("lru3", 3, 1, 21);

      // starvation: int promoted in its 5th eligible cycle, then mult (also starved), then div
      do_reset();
      log_q.delete();
      bus.div_tag = 40; bus.div_data = 32'h40;
      bus.mult_tag = 50; bus.mult_data = 32'h50;
      bus.int_tag = 60; bus.int_data = 32'h60;
      bus.div_valid = 1; bus.mult_valid = 1; bus.int_valid = 1;
      tick();
      bus.int_valid = 0;
      for (int i = 0; i < 9; i++) begin
         bus.div_valid = bus.div_ready;
         bus.mult_valid = bus.mult_ready;
         tick();
      end
      idle();
      repeat (8) tick();
      chk_log("starve0", 0, 3, 40);
      chk_log("starve3", 3, 3, 40);
      chk_log("starve4", 4, 0, 60);
      chk_log("starve5", 5, 2, 50);
      chk_log("starve6", 6, 3, 40);

      // full mem FIFO under div pressure; order preserved across pointer wrap
      do_reset();
      log_q.delete();
      bus.div_valid = 1; bus.div_tag = 30; bus.div_data = 32'h30;
      bus.mem_valid = 1; bus.mem_tag = 7; bus.mem_data = 32'h707;
      tick();
      bus.mem_tag = 8; bus.mem_data = 32'h808;
      bus.div_valid = bus.div_ready;
      tick();
      chk("full_mem_ready", 64'(bus.mem_ready), 0);
      bus.mem_tag = 9; bus.mem_data = 32'h909;
      n = 0;
      while (!bus.mem_ready && n < 20) begin
         bus.div_valid = bus.div_ready;
         tick();
         n++;
      end
      chk("full_wait_bounded", 64'(n < 20), 1);
      tick();
      idle();
      repeat (10) tick();
      foreach (log_q[i]) if (log_q[i][7:6] == 2'd1) memlog.push_back(log_q[i]);
      chk("full_count", 64'(memlog.size()), 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("full_order%0d", i), 64'(i < memlog.size() ? memlog[i][5:0] : 6'h3f), 64'(7 + i));

      // flush with int and mult each holding two entries
      do_reset();
      bus.div_valid = 1; bus.div_tag = 11; bus.div_data = 32'hb;
      bus.int_valid = 1; bus.int_tag = 12; bus.int_data = 32'hc;
      bus.mult_valid = 1; bus.mult_tag = 13; bus.mult_data = 32'hd;
      tick();
      bus.div_valid = 0;
      bus.int_tag = 14; bus.mult_tag = 15;
      tick();
      idle();
      flush = 1;
      bus.mem_valid = 1; bus.mem_tag = 33;
      #1 chk("flush_ready", 64'({bus.div_ready, bus.mult_ready, bus.mem_ready, bus.int_ready}), 0);
      chk("flush_pre_valid", 64'({bus.cdb_valid, bus.cdb_tag}), 64'({1'b1, 6'd11}));
      tick();
      flush = 0;
      idle();
      #1 chk("flush_valid", 64'(bus.cdb_valid), 0);
      chk("flush_ready_after", 64'({bus.div_ready, bus.mult_ready, bus.mem_ready, bus.int_ready}), 64'hf);
      tick();
      chk("flush_valid2", 64'(bus.cdb_valid), 0);

      // async reset in the middle of a burst
      bus.int_valid = 1; bus.int_tag = 21; bus.mem_valid = 1; bus.mem_tag = 22;
      tick();
      bus.int_tag = 23; bus.mem_tag = 24;
      tick();
      idle();
      chk("burst_valid", 64'(bus.cdb_valid), 1);
      #1 rst_n = 1'b0;
      #1 chk("async_valid", 64'(bus.cdb_valid), 0);
      chk("async_tag", 64'(bus.cdb_tag), 0);
      #3 rst_n = 1'b1;
      repeat (3) tick();
      chk("post_reset_idle", 64'(bus.cdb_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates completed results from the int, mem, mult and div execution units onto the single Common Data Bus (CDB).
- Each unit pushes {tag, data} into a private result FIFO. The arbiter grants one FIFO head per cycle and drives a registered CDB broadcast to the ROB and reservation stations.
- Priority is div > mult > LRU(int, mem), with a starvation guard. A flush input empties every buffer on a branch mispredict.

Parameters:
- DATA_W, 32, CDB data width
- TAG_W, 6, ROB tag width
- DEPTH, 2, entries per source FIFO (power of two, >=2)
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before a source is promoted (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all buffered results
- int_valid / mem_valid / mult_valid / div_valid  in  1 each  result presented by the unit
- int_ready / mem_ready / mult_ready / div_ready  out  1 each  FIFO can accept this cycle
- int_tag / mem_tag / mult_tag / div_tag  in  TAG_W each  ROB tag of the result
- int_data / mem_data / mult_data / div_data  in  DATA_W each  result value
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast data
- cdb_src  out  2  granted source: 0=int, 1=mem, 2=mult, 3=div

Behaviour:
- Reset (rst_n=0, async):
  - All FIFOs empty; all starve counters 0; lru=1.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - All *_ready=1 once rst_n=1.
- Push:
  - An entry is written when x_valid && x_ready at a rising edge.
  - x_ready = (count_x < DEPTH) && !flush. It is combinational from state only, with no pop-through: a full FIFO shows ready=0 even in a cycle where it is being popped.
  - x_valid with x_ready=0 is a producer protocol violation; the data is dropped and no assertion is required from this block.
- Eligibility: an entry written at edge N is eligible for grant in the cycle after edge N. There is no bypass from inputs to the CDB.
- Grant (combinational, among non-empty FIFOs):
  1. If any source's starve counter == STARVE_LIMIT, grant the starved source first, in order int, mem, mult, div.
  2. Else div, else mult.
  3. Else if int and mem are both non-empty: int when lru=1, mem when lru=0.
  4. Else whichever of int or mem is non-empty.
  5. No grant if all FIFOs are empty.
- Pop and broadcast: the granted head is popped at the edge. At the same edge, cdb_valid, cdb_tag, cdb_data and cdb_src are registered. Accept-to-broadcast latency is therefore at least 2 cycles.
- No grant: cdb_valid<=0; cdb_tag, cdb_data and cdb_src hold their last values.
- LRU: lru<=0 on an int grant, lru<=1 on a mem grant, and it holds otherwise. Starvation-promoted grants update lru in the same way.
- Starve counters (per source):
  - Cleared on grant or when the FIFO is empty.
  - Otherwise +1 per cycle, saturating at STARVE_LIMIT.
- FIFO pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. The count is (log2(DEPTH)+1) bits wide. A push and a pop on the same FIFO at the same edge leave the count unchanged.
- Flush (sampled at the edge, flush=1):
  - All counts and pointers go to 0 and starve counters go to 0.
  - cdb_valid<=0; no grant or pop occurs that cycle.
  - Pushes in the flush cycle are dropped (ready=0).
  - lru is unchanged.
  - The cycle after flush deasserts behaves as after reset, except for lru.
- Async reset mid-stream discards everything immediately, including the in-flight cdb_valid.
- Throughput: one broadcast per cycle whenever any FIFO is non-empty.

Test Plan:
- Reset, single push: int_valid with tag=5, data=0x1234 at cycle 1 -> cdb_valid=1, tag=5, data=0x1234, src=0 in cycle 3 only; int_ready stays 1.
- Fixed priority: div, mult and int each push at the same edge (tags 1, 2, 3) -> CDB order over 3 consecutive cycles is tag1 (src3), tag2 (src2), tag3 (src0).
- LRU alternation: int and mem each continuously refilled after reset -> grants go int, mem, int, mem; lru toggles each cycle.
- Starvation: div and mult kept non-empty every cycle, plus one int entry, STARVE_LIMIT=4 -> int is granted in the 5th eligible cycle, then div/mult priority resumes.
- Full/backpressure: push 2 mem entries while div is kept busy -> mem_ready=0 after the second push. A third mem_valid is not accepted until mem wins a grant. Data order is preserved across the wrap (tags 7, 8, 9 broadcast in that order).
- Flush: flush asserted with int and mult each holding 2 entries -> next cycle cdb_valid=0 and all *_ready=1. The cycle after that, with no new pushes, cdb_valid stays 0. Asserting rst_n=0 mid-burst drops cdb_valid to 0 immediately.
